// File: rtl/sw_edge_pkg.sv
// Shared types for the switch edge debouncer: edge-mode encoding and the
// helper that decides whether a debounced transition should be reported.
package sw_edge_pkg;

    localparam logic [1:0] EDGE_ENC_RISE = 2'b00;
    localparam logic [1:0] EDGE_ENC_FALL = 2'b01;
    localparam logic [1:0] EDGE_ENC_BOTH = 2'b10;
    localparam logic [1:0] EDGE_ENC_NONE = 2'b11;

    typedef enum logic [1:0] {
        EDGE_RISE = EDGE_ENC_RISE,
        EDGE_FALL = EDGE_ENC_FALL,
        EDGE_BOTH = EDGE_ENC_BOTH,
        EDGE_NONE = EDGE_ENC_NONE
    } edge_mode_t;

    // new_level is the value the debounced level is about to take.
    function automatic logic edge_qualifies(input edge_mode_t mode, input logic new_level);
        logic hit;
        hit = 1'b0;
        case (mode)
            EDGE_RISE: hit = new_level;
            EDGE_FALL: hit = ~new_level;
            EDGE_BOTH: hit = 1'b1;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: 2-flop synchroniser, stability counter, debounced
// level register and a one-cycle pulse for qualifying level changes.
module sw_debounce_ch
    import sw_edge_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_raw,
    input  edge_mode_t edge_mode,
    output logic       level,
    output logic       edge_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             sync_lvl;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             pulse_nxt;

    assign sync_lvl = sync_q[1];

    // The update fires on the edge where the count would reach
    // DEBOUNCE_CYCLES, so the counter itself never holds that value.
    always_comb begin
        cnt_nxt   = '0;
        level_nxt = level;
        pulse_nxt = 1'b0;
        if (sync_lvl != level) begin
            if (cnt == CNT_LAST) begin
                level_nxt = sync_lvl;
                pulse_nxt = edge_qualifies(edge_mode, sync_lvl);
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            cnt        <= '0;
            level      <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], sw_raw};
            cnt        <= cnt_nxt;
            level      <= level_nxt;
            edge_pulse <= pulse_nxt;
        end
    end

endmodule

// File: rtl/sw_edge_debounce.sv
// Multi-channel switch debouncer with edge detection and optional sticky
// event flags (compiled in when SW_EDGE_STICKY_EN is defined).
module sw_edge_debounce
    import sw_edge_pkg::*;
#(
    parameter int unsigned NUM_BITS        = 18,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BITS-1:0] SW_pressed,
    input  logic [1:0]          edge_mode,
    input  logic [NUM_BITS-1:0] sticky_clr,
    output logic [NUM_BITS-1:0] SW_level,
    output logic [NUM_BITS-1:0] SW_edge_det,
    output logic [NUM_BITS-1:0] sticky
);

    edge_mode_t mode_sel;
    assign mode_sel = edge_mode_t'(edge_mode);

    for (genvar i = 0; i < NUM_BITS; i++) begin : g_ch
        sw_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .sw_raw    (SW_pressed[i]),
            .edge_mode (mode_sel),
            .level     (SW_level[i]),
            .edge_pulse(SW_edge_det[i])
        );
    end

`ifdef SW_EDGE_STICKY_EN
    // Set has priority over clear so a pulse coinciding with a clear is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky <= '0;
        end else begin
            sticky <= (sticky & ~sticky_clr) | SW_edge_det;
        end
    end
`else
    logic [NUM_BITS-1:0] unused_sticky_clr;
    assign unused_sticky_clr = sticky_clr;
    assign sticky = '0;
`endif

endmodule

// File: tb/tb_sw_edge_debounce.sv
// Self-checking bench for sw_edge_debounce: directed vector table, corner
// sequences and randomized stimulus against a window-based reference model.
module tb_sw_edge_debounce;

    localparam int unsigned NB = 18;
    localparam int unsigned DC = 4;
`ifdef SW_EDGE_STICKY_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] sw_pressed = '0;
    logic [1:0]    edge_mode = 2'b00;
    logic [NB-1:0] sticky_clr = '0;
    logic [NB-1:0] sw_level;
    logic [NB-1:0] sw_edge_det;
    logic [NB-1:0] sticky;

    always #10 clk = ~clk;

    sw_edge_debounce #(
        .NUM_BITS       (NB),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .SW_pressed (sw_pressed),
        .edge_mode  (edge_mode),
        .sticky_clr (sticky_clr),
        .SW_level   (sw_level),
        .SW_edge_det(sw_edge_det),
        .sticky     (sticky)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: raw_h[n] is the switch value present before edge n
    // (edges numbered from 1 after reset release). The debouncer sees that
    // value two edges later; the level flips at edge n when the last DC
    // observed samples all disagree with the current level.
    logic [NB-1:0] raw_h [0:8191];
    int            cyc;
    logic [NB-1:0] m_level;
    logic [NB-1:0] m_edge;
    logic [NB-1:0] m_sticky;

    function automatic logic [NB-1:0] obs_at(input int n);
        return (n >= 3) ? raw_h[n-2] : '0;
    endfunction

    function automatic logic mode_hit(input logic [1:0] m, input logic rising);
        case (m)
            2'b00:   return rising;
            2'b01:   return ~rising;
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        cyc      = 0;
        m_level  = '0;
        m_edge   = '0;
        m_sticky = '0;
    endtask

    task automatic model_edge(input logic [NB-1:0] sw, input logic [1:0] mode,
                              input logic [NB-1:0] clr);
        logic [NB-1:0] nl;
        logic [NB-1:0] ne;
        logic          all_diff;
        cyc = cyc + 1;
        raw_h[cyc] = sw;
        m_sticky = STICKY_ON ? ((m_sticky & ~clr) | m_edge) : '0;
        nl = m_level;
        ne = '0;
        if (cyc >= int'(DC)) begin
            for (int b = 0; b < int'(NB); b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < int'(DC); j++) begin
                    if (obs_at(cyc - j) == (obs_at(cyc - j) & ~(NB'(1) << b)) ? m_level[b] == 1'b0
                                                                                : m_level[b] == 1'b1)
                        all_diff = 1'b0;
                end
                if (all_diff) begin
                    nl[b] = ~m_level[b];
                    ne[b] = mode_hit(mode, ~m_level[b]);
                end
            end
        end
        m_level = nl;
        m_edge  = ne;
    endtask

    task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called #1 after a rising edge; drives inputs, advances one edge, checks.
    task automatic step(input logic [NB-1:0] sw, input logic [1:0] mode,
                        input logic [NB-1:0] clr);
        sw_pressed = sw;
        edge_mode  = mode;
        sticky_clr = clr;
        @(posedge clk);
        model_edge(sw, mode, clr);
        #1;
        chk("model_level", sw_level, m_level);
        chk("model_edge", sw_edge_det, m_edge);
        chk("model_sticky", sticky, m_sticky);
    endtask

    // Asserts reset mid-cycle, checks the outputs clear at once, releases
    // before the next rising edge.
    task automatic reset_pulse();
        #4;
        rst = 1'b1;
        #1;
        chk("rst_level", sw_level, '0);
        chk("rst_edge", sw_edge_det, '0);
        chk("rst_sticky", sticky, '0);
        #5;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [NB-1:0] sw;
        logic [1:0]    mode;
        logic [NB-1:0] exp_level;
        logic [NB-1:0] exp_edge;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] rs;
        logic [NB-1:0] flip;
        logic [NB-1:0] clr_r;
        int            c5;
        int            c11;

        // Rising edge on bit 5 applied before edge 1: level and pulse at
        // edge 6, pulse gone at edge 7.
        for (int i = 0; i < 5; i++) tbl[i] = '{18'h00020, 2'b00, 18'h00000, 18'h00000};
        tbl[5] = '{18'h00020, 2'b00, 18'h00020, 18'h00020};
        tbl[6] = '{18'h00020, 2'b00, 18'h00020, 18'h00000};

        model_reset();
        @(posedge clk);
        #1;
        reset_pulse();

        for (int i = 0; i < 3; i++) step('0, 2'b00, '0);
        chk("idle_level", sw_level, '0);
        chk("idle_edge", sw_edge_det, '0);
        chk("idle_sticky", sticky, '0);

        for (int i = 0; i < 7; i++) begin
            step(tbl[i].sw, tbl[i].mode, '0);
            chk($sformatf("tbl%0d_level", i), sw_level, tbl[i].exp_level);
            chk($sformatf("tbl%0d_edge", i), sw_edge_det, tbl[i].exp_edge);
        end

        // Three-cycle glitch must be swallowed.
        reset_pulse();
        for (int i = 0; i < 11; i++) begin
            step((i < 3) ? 18'h00020 : 18'h00000, 2'b00, '0);
            chk("glitch_level", sw_level, '0);
            chk("glitch_edge", sw_edge_det, '0);
        end

        // Both-edge mode: rise on 5, rise on 11, fall on 5.
        c5 = 0;
        c11 = 0;
        for (int i = 0; i < 21; i++) begin
            step((i < 7) ? 18'h00020 : (i < 14) ? 18'h00820 : 18'h00800, 2'b10, '0);
            if (sw_edge_det[5]) c5++;
            if (sw_edge_det[11]) c11++;
        end
        chk("both_pulses_b5", NB'(c5), NB'(2));
        chk("both_pulses_b11", NB'(c11), NB'(1));
        chk("both_final_level", sw_level, 18'h00800);

        // Sticky: clear coinciding with a new set keeps the flag; clear alone drops it.
        for (int i = 0; i < 7; i++) step(18'h00820, 2'b10, '0);
        for (int i = 0; i < 5; i++) step(18'h00800, 2'b10, '0);
        step(18'h00800, 2'b10, '0);
        chk("sticky_new_pulse", NB'(sw_edge_det[5]), NB'(1));
        step(18'h00800, 2'b10, 18'h00020);
        chk("sticky_set_wins", NB'(sticky[5]), NB'(STICKY_ON));
        step(18'h00800, 2'b10, 18'h00020);
        chk("sticky_clr_alone", NB'(sticky[5]), NB'(0));

        // Randomized traffic.
        rs = 18'h00800;
        for (int t = 0; t < 1500; t++) begin
            flip = '0;
            for (int b = 0; b < int'(NB); b++)
                if ($urandom_range(9) == 0) flip[b] = 1'b1;
            rs = rs ^ flip;
            clr_r = ($urandom_range(3) == 0) ? NB'($urandom) : '0;
            step(rs, 2'($urandom_range(3)), clr_r);
        end

        // Reset in the middle of a debounce; held switch reported at edge 6.
        for (int i = 0; i < 10; i++) step(18'h3F000, 2'b00, '0);
        for (int i = 0; i < 4; i++) step(18'h3F001, 2'b00, '0);
        reset_pulse();
        for (int i = 1; i <= 7; i++) begin
            step(18'h3F001, 2'b00, '0);
            chk($sformatf("rst_rel_edge%0d_b0", i), NB'(sw_edge_det[0]), NB'(i == 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_edge_debounce.md
SW_EDGE_DEBOUNCE -- requirements
Module: sw_edge_debounce

Interface
REQ-001 Parameter NUM_BITS, default 18, number of independent switch channels (>=1).
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles required to accept a new level (>=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 SW_pressed  input  NUM_BITS  raw asynchronous switch levels.
REQ-006 edge_mode  input  2  edge select, common to all channels: 00 rising, 01 falling, 10 both, 11 none.
REQ-007 sticky_clr  input  NUM_BITS  per-channel clear of sticky flags.
REQ-008 SW_level  output  NUM_BITS  debounced, registered switch level.
REQ-009 SW_edge_det  output  NUM_BITS  one-cycle pulse per qualifying debounced edge.
REQ-010 sticky  output  NUM_BITS  per-channel latched edge event.

Function
REQ-011 Each SW_pressed bit SHALL pass through a 2-flop synchroniser before any other logic.
REQ-012 Each channel SHALL hold a counter of width $clog2(DEBOUNCE_CYCLES+1), cleared whenever synchronised input equals SW_level.
REQ-013 When synchronised input differs from SW_level, counter SHALL increment; on the edge where it would reach DEBOUNCE_CYCLES, SW_level SHALL take the new value and counter SHALL clear.
REQ-014 Input change stable from before rising edge k SHALL update SW_level at edge k+1+DEBOUNCE_CYCLES; glitch shorter than DEBOUNCE_CYCLES synchronised cycles SHALL produce no SW_level change.
REQ-015 SW_edge_det[i] SHALL assert on the same edge SW_level[i] updates if the transition matches edge_mode, and deassert on the next edge.
REQ-016 edge_mode SHALL be sampled on the SW_level update edge; mode 11 SHALL suppress all pulses but not SW_level updates.
REQ-017 Channels SHALL be fully independent; simultaneous edges on any number of channels SHALL each pulse.
REQ-018 sticky[i] SHALL set on edge after SW_edge_det[i] high and clear on edge after sticky_clr[i] high; simultaneous set and clear SHALL leave sticky[i] set.

Reset
REQ-019 rst high SHALL immediately clear synchronisers, counters, SW_level, SW_edge_det and sticky to 0.
REQ-020 rst asserted mid-debounce SHALL discard the partial count; a switch held high through reset SHALL be reported as a rising edge DEBOUNCE_CYCLES+2 edges after rst release.

Configuration
REQ-021 Macro SW_EDGE_STICKY_EN defined: sticky logic per REQ-018 compiled in.
REQ-022 Macro SW_EDGE_STICKY_EN undefined: sticky SHALL be driven constant 0, sticky_clr ignored, no sticky flops synthesised; port list unchanged.

Structure
REQ-023 Package sw_edge_pkg SHALL hold edge_mode_t enum (EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_NONE) and encoding constants.
REQ-024 Sub-module sw_debounce_ch SHALL implement one channel (sync, counter, level, pulse); top generates NUM_BITS instances plus sticky logic.

Verification (NUM_BITS=18, DEBOUNCE_CYCLES=4, 20 ns clock)
REQ-025 rst released, SW_pressed=0 for 60 ns -> SW_level=0, SW_edge_det=0, sticky=0.
REQ-026 edge_mode=00, SW_pressed=18'h00020 before edge k -> SW_level[5] and SW_edge_det[5] high at edge k+5, pulse low at k+6.
REQ-027 SW_pressed[5] high for 3 cycles then low -> no SW_level or SW_edge_det change.
REQ-028 edge_mode=10, SW_pressed 18'h00020 -> 18'h00820, then bit 5 released -> pulses on bit 11 (rise) and bit 5 (fall), each one cycle.
REQ-029 SW_EDGE_STICKY_EN defined, sticky_clr[5] high on same edge as new pulse -> sticky[5] remains 1; clr alone next cycle -> sticky[5]=0.
REQ-030 rst pulsed at count 2 with SW_pressed[0] high -> all outputs 0 immediately; SW_edge_det[0] pulses at edge 6 after release.
